matrix_serial_loader: RTL and testbench
=======================================

// Module: matrix_serial_loader
// PURPOSE
// - Upstream stage of the 8x8 matrix multiplier: turns a bit-serial stream from board switches into 8-bit words.
// - Writes 64 words into matrix RAM A, then 64 words into matrix RAM B, then pulses start to the multiplier.
// - Holds off until the multiplier reports done, then returns to idle ready for a new load.
// PARAMETERS
// - DATA_W   8   element width (signed two's complement, MSB first on the wire)
// - DEPTH    64  elements per matrix (8x8)
// - ADDR_W   6   RAM address width, log2(DEPTH)
// PORTS
// - clk          in   1       system clock, all logic on posedge
// - rst          in   1       asynchronous, active-high reset
// - load_en      in   1       level; high = accept a load session, low = abort/idle
// - sdi          in   1       serial data bit (async, from switch)
// - sstb         in   1       serial strobe (async); each rising edge samples sdi
// - mult_done    in   1       multiplier finished (level, held high)
// - wr_addr      out  ADDR_W  RAM write address (shared by A and B)
// - wr_data      out  DATA_W  RAM write data (shared)
// - we_a         out  1       one-cycle write enable to RAM A
// - we_b         out  1       one-cycle write enable to RAM B
// - start_mult   out  1       one-cycle start pulse to multiplier
// - busy         out  1       high in any state except IDLE
// - word_cnt     out  ADDR_W+1  words written in current matrix (0..DEPTH)
// BEHAVIOUR
// - Reset: state IDLE; wr_addr=0, wr_data=0, we_a=we_b=0, start_mult=0, busy=0, word_cnt=0; shift reg, bit count, sync flops cleared.
// - sdi and sstb each pass a 2-flop synchronizer; a third flop on sstb gives edge = s2 & ~s3.
// - On edge in LOAD_A/LOAD_B: shreg <= {shreg[DATA_W-2:0], sdi_sync}; bit_cnt++. Edges in other states ignored.
// - When the DATA_W-th bit is sampled: next cycle wr_data = assembled word, we_x=1 for exactly one cycle,
//   wr_addr = current address; address and word_cnt increment after the write; bit_cnt wraps to 0 same cycle
//   the last bit is taken, so a following edge is never lost.
// - Latency: raw sstb rise to sample = 3 clk; last-bit sample to write pulse = 1 clk.
// - FSM: IDLE -> LOAD_A when load_en=1.
//   LOAD_A -> LOAD_B on the cycle of the DEPTH-th A write; wr_addr wraps 0, word_cnt=0.
//   LOAD_B -> KICK on the cycle of the DEPTH-th B write.
//   KICK: start_mult=1 for one cycle -> WAIT.
//   WAIT -> IDLE when mult_done=1; stays in IDLE until load_en is low then high again (no re-trigger on held load_en).
// - Abort: load_en low in LOAD_A/LOAD_B -> IDLE next cycle; partial word discarded, no write issued, counters cleared.
//   load_en low in KICK/WAIT has no effect (multiplier run completes).
// - Simultaneous edge and completed-word write: both honoured same cycle (new bit shifts in, old word written).
// - Reset mid-operation: immediate return to reset values; RAM contents untouched, partially loaded matrix stays stale.
// - we_a and we_b are never high together; neither is high outside LOAD_A/LOAD_B (+1 cycle for final write).
// - No arithmetic on data: bits stored unchanged, sign handled by downstream MAC.
// STRUCTURE
// - Shared package: state encoding (IDLE, LOAD_A, LOAD_B, KICK, WAIT), DATA_W/DEPTH/ADDR_W defaults shared with RAM A/B and multiplier.
// - One sub-module: sync_edge_detect (2-flop sync + rising-edge pulse), instanced for sstb; sdi uses the same 2-flop sync path.
// - Top: FSM, shift register, bit/word counters, write-port registers.
// TESTING
// - Reset then load_en=1, stream A[i]=i, B[i]=-i (MSB first) -> 128 write pulses, we_a at addr 0..63 data i, we_b at addr 0..63 data -i (8'hFF.. two's comp).
// - After 128th word -> start_mult high exactly 1 cycle; hold mult_done=0 100 cycles -> busy=1, no writes; mult_done=1 -> IDLE next cycle.
// - Drop load_en after 5 bits of word 10 of A -> IDLE, no write for word 10, word_cnt=0; reload restarts at addr 0.
// - Strobe edges every 4 clk (minimum) across a word boundary -> no bit lost, words 8'hA5, 8'h3C written correctly.
// - Assert rst during LOAD_B word 30 -> all outputs zero same cycle; edges afterward ignored until load_en re-asserted.
// - Hold load_en high through mult_done -> no second load starts until load_en toggles low/high.

Source files
------------

// File: rtl/matrix_serial_loader_pkg.sv
// matrix_serial_loader_pkg: sizes and FSM encoding shared with RAM A/B and the multiplier.
package matrix_serial_loader_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 64;
    localparam int DEF_ADDR_W = 6;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        KICK,
        WAIT
    } state_e;

endpackage

// File: rtl/matrix_serial_loader_sync_edge_detect.sv
// sync_edge_detect: 2-flop synchronizers for a strobe and its data bit, plus a rising-edge pulse on the strobe.
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic strb_i,
    input  logic dat_i,
    output logic strb_rise_o,
    output logic dat_o
);

    logic [2:0] strb_q;
    logic [1:0] dat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strb_q <= '0;
            dat_q  <= '0;
        end else begin
            strb_q <= {strb_q[1:0], strb_i};
            dat_q  <= {dat_q[0], dat_i};
        end
    end

    assign strb_rise_o = strb_q[1] & ~strb_q[2];
    assign dat_o       = dat_q[1];

endmodule

// File: rtl/matrix_serial_loader.sv
// matrix_serial_loader: assembles bit-serial switch input into words, fills RAM A then RAM B,
// kicks the multiplier and waits for it to finish.
module matrix_serial_loader
    import matrix_serial_loader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic              sdi,
    input  logic              sstb,
    input  logic              mult_done,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              we_a,
    output logic              we_b,
    output logic              start_mult,
    output logic              busy,
    output logic [ADDR_W:0]   word_cnt
);

    localparam int BIT_W = $clog2(DATA_W);
    localparam int CNT_W = ADDR_W + 1;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d, wr_data_q, wr_data_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_a_q, we_a_d, we_b_q, we_b_d, start_q, start_d, hold_q, hold_d;
    logic              rise, sdi_s, take, last, wrote, full;

    sync_edge_detect u_sync (
        .clk         (clk),
        .rst         (rst),
        .strb_i      (sstb),
        .dat_i       (sdi),
        .strb_rise_o (rise),
        .dat_o       (sdi_s)
    );

    always_comb begin
        take    = rise && load_en && (state_q == LOAD_A || state_q == LOAD_B);
        last    = take && (bit_cnt_q == BIT_W'(DATA_W - 1));
        wrote   = we_a_q || we_b_q;
        full    = wrote && (addr_q == ADDR_W'(DEPTH - 1));
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (load_en && !hold_q) ? LOAD_A : IDLE;
            LOAD_A:  state_d = !load_en ? IDLE : (full ? LOAD_B : LOAD_A);
            LOAD_B:  state_d = !load_en ? IDLE : (full ? KICK : LOAD_B);
            KICK:    state_d = WAIT;
            WAIT:    state_d = mult_done ? IDLE : WAIT;
            default: state_d = IDLE;
        endcase
        // A finished run must see load_en drop before another load may begin
        hold_d    = (state_q == WAIT && mult_done) || (hold_q && load_en);
        shreg_d   = take ? {shreg_q[DATA_W-2:0], sdi_s} : shreg_q;
        bit_cnt_d = last ? '0 : bit_cnt_q + BIT_W'(take);
        we_a_d    = last && state_q == LOAD_A;
        we_b_d    = last && state_q == LOAD_B;
        wr_data_d = last ? shreg_d : wr_data_q;
        addr_d    = addr_q + ADDR_W'(wrote);
        cnt_d     = (full && state_q == LOAD_A) ? '0 : cnt_q + CNT_W'(wrote);
        start_d   = state_d == KICK;
        if (state_d == IDLE) begin
            shreg_d   = '0;
            bit_cnt_d = '0;
            addr_d    = '0;
            cnt_d     = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            wr_data_q <= '0;
            we_a_q    <= 1'b0;
            we_b_q    <= 1'b0;
            start_q   <= 1'b0;
            hold_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            wr_data_q <= wr_data_d;
            we_a_q    <= we_a_d;
            we_b_q    <= we_b_d;
            start_q   <= start_d;
            hold_q    <= hold_d;
        end
    end

    assign wr_addr    = addr_q;
    assign wr_data    = wr_data_q;
    assign we_a       = we_a_q;
    assign we_b       = we_b_q;
    assign start_mult = start_q;
    assign busy       = state_q != IDLE;
    assign word_cnt   = cnt_q;

endmodule

// File: tb/tb_matrix_serial_loader.sv
// tb_matrix_serial_loader: directed vectors with hand-computed expectations for the serial matrix loader.
module tb_matrix_serial_loader;

    logic       clk = 1'b0, rst = 1'b1, load_en = 1'b0, sdi = 1'b0, sstb = 1'b0, mult_done = 1'b0;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       we_a, we_b, start_mult, busy;
    logic [6:0] word_cnt;

    matrix_serial_loader dut (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en),
        .sdi        (sdi),
        .sstb       (sstb),
        .mult_done  (mult_done),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .we_a       (we_a),
        .we_b       (we_b),
        .start_mult (start_mult),
        .busy       (busy),
        .word_cnt   (word_cnt)
    );

    always #5 clk = ~clk;

    logic [7:0] a_mem [64];
    logic [7:0] b_mem [64];
    int         a_cnt = 0, b_cnt = 0, st_cnt = 0, both = 0;
    logic [5:0] last_addr = '0;
    logic [7:0] last_data = '0;

    always @(negedge clk) begin
        if (we_a && we_b) both++;
        if (we_a) begin a_mem[wr_addr] = wr_data; a_cnt++; end
        if (we_b) begin b_mem[wr_addr] = wr_data; b_cnt++; end
        if (we_a || we_b) begin last_addr = wr_addr; last_data = wr_data; end
        if (start_mult) st_cnt++;
    end

    int pass = 0, total = 0;

    task automatic ck(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", n, act, exp);
        else pass++;
    endtask

    // one strobe every 4 clocks, the fastest rate the synchronizer supports
    task automatic send_bits(input logic [7:0] w, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            @(negedge clk);
            sdi  = w[i];
            sstb = 1'b1;
            repeat (2) @(negedge clk);
            sstb = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        string      name;
        logic       b_sel;
        int         addr;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [8];
    int   n0, a0, err;

    initial begin
        tbl[0] = '{"a0",  1'b0, 0,  8'h00};
        tbl[1] = '{"a37", 1'b0, 37, 8'h25};
        tbl[2] = '{"a63", 1'b0, 63, 8'h3F};
        tbl[3] = '{"b1",  1'b1, 1,  8'hFF};
        tbl[4] = '{"b2",  1'b1, 2,  8'hFE};
        tbl[5] = '{"b10", 1'b1, 10, 8'hF6};
        tbl[6] = '{"b32", 1'b1, 32, 8'hE0};
        tbl[7] = '{"b63", 1'b1, 63, 8'hC1};

        settle(3);
        ck("reset_outs", {wr_addr, wr_data, we_a, we_b, start_mult, busy, word_cnt}, 0);
        @(negedge clk);
        rst     = 1'b0;
        load_en = 1'b1;
        settle(1);
        ck("busy_on_load", busy, 1);

        for (int i = 0; i < 64; i++) send_bits(8'(i), 8);
        settle(2);
        ck("a_writes", a_cnt, 64);
        ck("a_done_cnt", word_cnt, 0);
        ck("a_done_addr", wr_addr, 0);
        for (int i = 0; i < 64; i++) send_bits(8'(-i), 8);
        settle(4);
        ck("b_writes", b_cnt, 64);
        ck("b_done_cnt", word_cnt, 64);
        ck("start_pulse", st_cnt, 1);
        ck("we_exclusive", both, 0);
        for (int i = 0; i < 8; i++)
            ck(tbl[i].name, tbl[i].b_sel ? b_mem[tbl[i].addr] : a_mem[tbl[i].addr], tbl[i].exp);
        err = 0;
        for (int i = 0; i < 64; i++)
            if (a_mem[i] !== 8'(i) || b_mem[i] !== 8'(-i)) err++;
        ck("all_words", err, 0);

        n0 = a_cnt + b_cnt;
        send_bits(8'h77, 8);
        settle(100 - 32);
        ck("wait_no_writes", a_cnt + b_cnt, n0);
        ck("wait_busy", busy, 1);
        ck("wait_one_start", st_cnt, 1);
        @(negedge clk);
        mult_done = 1'b1;
        settle(1);
        ck("done_idle", busy, 0);
        settle(20);
        ck("no_retrigger", busy, 0);
        @(negedge clk);
        mult_done = 1'b0;
        load_en   = 1'b0;
        settle(2);
        @(negedge clk);
        load_en = 1'b1;

        a0 = a_cnt;
        for (int i = 0; i < 10; i++) send_bits(8'(i + 100), 8);
        send_bits(8'hC3, 5);
        @(negedge clk);
        load_en = 1'b0;
        settle(1);
        ck("abort_idle", busy, 0);
        ck("abort_cnt", word_cnt, 0);
        settle(3);
        ck("abort_writes", a_cnt - a0, 10);
        ck("abort_last_addr", last_addr, 9);
        @(negedge clk);
        load_en = 1'b1;
        send_bits(8'h5A, 8);
        settle(2);
        ck("reload_addr", last_addr, 0);
        ck("reload_data", last_data, 8'h5A);
        send_bits(8'hA5, 8);
        send_bits(8'h3C, 8);
        settle(2);
        ck("burst_w1", a_mem[1], 8'hA5);
        ck("burst_w2", a_mem[2], 8'h3C);

        @(negedge clk);
        load_en = 1'b0;
        settle(2);
        @(negedge clk);
        load_en = 1'b1;
        for (int i = 0; i < 64; i++) send_bits(8'(i) ^ 8'h55, 8);
        for (int i = 0; i < 30; i++) send_bits(8'(-i), 8);
        send_bits(8'hF0, 3);
        ck("pre_rst_cnt", word_cnt, 30);
        #2;
        rst = 1'b1;
        #1;
        ck("rst_outs", {wr_addr, wr_data, we_a, we_b, start_mult, busy, word_cnt}, 0);
        load_en = 1'b0;
        settle(3);
        @(negedge clk);
        rst = 1'b0;
        n0  = a_cnt + b_cnt;
        send_bits(8'hFF, 8);
        settle(2);
        ck("post_rst_ignored", a_cnt + b_cnt, n0);
        ck("post_rst_idle", busy, 0);
        @(negedge clk);
        load_en = 1'b1;
        send_bits(8'h81, 8);
        settle(2);
        ck("rearm_data", a_mem[0], 8'h81);
        ck("rearm_count", a_cnt + b_cnt, n0 + 1);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
